// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control FSM.
// Includes the state enum (with TRAP, reachable only when MC_CTRL_TRAP_EN is defined).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef logic [1:0] imm_src_t;
    localparam imm_src_t IMM_I = 2'b00;
    localparam imm_src_t IMM_S = 2'b01;
    localparam imm_src_t IMM_B = 2'b10;
    localparam imm_src_t IMM_J = 2'b11;

    typedef logic [1:0] result_src_t;
    localparam result_src_t RES_ALUOUT = 2'b00;
    localparam result_src_t RES_MEM    = 2'b01;
    localparam result_src_t RES_ALU    = 2'b10;

    typedef logic [1:0] src_a_t;
    localparam src_a_t SRCA_PC    = 2'b00;
    localparam src_a_t SRCA_OLDPC = 2'b01;
    localparam src_a_t SRCA_RS1   = 2'b10;

    typedef logic [1:0] src_b_t;
    localparam src_b_t SRCB_RS2  = 2'b00;
    localparam src_b_t SRCB_IMM  = 2'b01;
    localparam src_b_t SRCB_FOUR = 2'b10;

    typedef logic [2:0] alu_ctl_t;
    localparam alu_ctl_t ALU_ADD = 3'b000;
    localparam alu_ctl_t ALU_SUB = 3'b001;
    localparam alu_ctl_t ALU_AND = 3'b010;
    localparam alu_ctl_t ALU_OR  = 3'b011;
    localparam alu_ctl_t ALU_SLT = 3'b101;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALUOP_ADD   = 2'b00;
    localparam alu_op_t ALUOP_SUB   = 2'b01;
    localparam alu_op_t ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic        adr_src;
        logic        reg_write;
        logic        pc_write;
        result_src_t result_src;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    // Moore outputs of each state; the data-dependent strobes are added in the top.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.result_src = RES_ALU;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_read = 1'b1;
                c.adr_src  = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.pc_write   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic imm_src_t imm_decode(logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE: return IMM_I;
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: maps the FSM's alu_op plus instruction fields to alu_control.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type so addi never becomes sub
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle RV32I control FSM; optional illegal-opcode trap with MC_CTRL_TRAP_EN.
// state    | meaning
// FETCH    | read instr at PC, PC+4 -> PC on mem_ready
// DECODE   | compute branch target, dispatch on opcode
// MEMADR   | rs1 + imm -> data address
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | load data -> rd
// MEMWRITE | store access, wait for mem_ready
// EXECR    | R-type ALU op
// EXECI    | I-type ALU op
// ALUWB    | alu_out -> rd
// JAL      | jump to target, PC+4 computed for rd
// BRANCH   | rs1 - rs2, conditional PC load
// TRAP     | unsupported opcode, sticky until reset
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t     state, nxt;
    ctrl_t      ctrl_q;
    logic [2:0] alu_ctl_dec;
    logic       fetch_done, branch_take;

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECR;
                    OP_ITYPE:          nxt = S_EXECI;
                    OP_JAL:            nxt = S_JAL;
                    OP_BRANCH:         nxt = S_BRANCH;
`ifdef MC_CTRL_TRAP_EN
                    default:           nxt = S_TRAP;
`else
                    default:           nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
            S_EXECR:    nxt = S_ALUWB;
            S_EXECI:    nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_JAL:      nxt = S_ALUWB;
            S_BRANCH:   nxt = S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RESET_STATE;
            ctrl_q <= state_ctrl(RESET_STATE);
        end else begin
            state  <= nxt;
            ctrl_q <= state_ctrl(nxt);
        end
    end

    mc_alu_dec u_alu_dec (
        .alu_op      (ctrl_q.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (alu_ctl_dec)
    );

    assign fetch_done  = (state == S_FETCH) && mem_ready;
    assign branch_take = (state == S_BRANCH) &&
                         (((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero));

    // Everything is gated by rst_n so the datapath sees no strobes while reset is held.
    assign mem_read    = rst_n & ctrl_q.mem_read;
    assign mem_write   = rst_n & ctrl_q.mem_write;
    assign adr_src     = rst_n & ctrl_q.adr_src;
    assign reg_write   = rst_n & ctrl_q.reg_write;
    assign ir_write    = rst_n & fetch_done;
    assign pc_write    = rst_n & (ctrl_q.pc_write | fetch_done | branch_take);
    assign result_src  = rst_n ? ctrl_q.result_src : 2'b00;
    assign alu_src_a   = rst_n ? ctrl_q.alu_src_a : 2'b00;
    assign alu_src_b   = rst_n ? ctrl_q.alu_src_b : 2'b00;
    assign imm_src     = rst_n ? imm_decode(opcode) : 2'b00;
    assign alu_control = rst_n ? alu_ctl_dec : 3'b000;

`ifdef MC_CTRL_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_q <= 1'b0;
        else        trap_q <= (nxt == S_TRAP);
    end
    assign illegal_instr = rst_n & trap_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback for one instruction at a time, and drives the datapath mux selects and write strobes. It also drives `imm_src` into the immediate generator and `alu_control` into the ALU. A memory ready handshake stretches fetch and data accesses.

Parameters:
- RESET_STATE, FETCH: state entered on reset (kept as a parameter for bring-up only).

Ports:
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- opcode  in  7  instr[6:0] from the IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- adr_src  out  1  0 = PC, 1 = ALU-out register
- ir_write  out  1  load IR and old_pc
- pc_write  out  1  load PC
- reg_write  out  1  register file write enable
- result_src  out  2  00 = alu_out reg, 01 = mem data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  trap flag (see Optional Feature)

Behaviour:
- Reset: asynchronous, state <= FETCH. While rst_n = 0, every output is forced to 0.
- Moore FSM. Outputs are decoded from state, except these, which are combinational:
  - pc_write in BEQ
  - ir_write and pc_write in FETCH
  - imm_src
- imm_src, decoded from opcode in every state:
  - 0000011 and 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else -> 00
- FETCH:
  - mem_read = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, ALU add, result_src = 10.
  - While mem_ready = 0, hold with no strobes.
  - On mem_ready = 1: ir_write = 1 and pc_write = 1 in that same cycle, then -> DECODE.
- DECODE: alu_src_a = 01, alu_src_b = 01, ALU add (latches the branch target). Next state by opcode:
  - load or store -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - anything else -> FETCH
- MEMADR: alu_src_a = 10, alu_src_b = 01, add. Next -> MEMREAD if opcode is a load, else -> MEMWRITE.
- MEMREAD: mem_read = 1, adr_src = 1. Hold until mem_ready, then -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Next -> FETCH.
- MEMWRITE: mem_write = 1, adr_src = 1. Hold until mem_ready, then -> FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, ALU op decoded from funct3/funct7b5. Next -> ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, ALU op decoded from funct3 (funct7b5 ignored). Next -> ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next -> FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1. Next -> ALUWB (writes PC+4 to rd).
- BRANCH: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00. Next -> FETCH.
  - pc_write = zero when funct3 = 000.
  - pc_write = !zero when funct3 = 001.
  - pc_write = 0 for any other funct3.
- ALU decode (R-type):
  - 000 with funct7b5 = 1 -> sub, 000 with funct7b5 = 0 -> add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - any other -> add
- Cycle counts with mem_ready tied high:
  - R-type, I-type, JAL: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- Reset asserted mid-instruction: immediate return to FETCH; no partial writeback.

Optional Feature:
- Macro MC_CTRL_TRAP_EN.
- Defined: an unsupported opcode in DECODE -> TRAP state.
  - TRAP: illegal_instr = 1, all strobes 0.
  - TRAP is sticky until rst_n.
- Undefined: an unsupported opcode -> FETCH; illegal_instr is tied to 0.
- The port exists in both builds.

Decomposition:
- Package `mc_ctrl_pkg` holds:
  - state enum
  - opcode constants
  - imm_src, result_src, alu_src_a/b and alu_control encodings as typedef'd localparams
- One sub-module, `mc_alu_dec`: a combinational decoder from (alu_op, funct3, funct7b5, opcode[5]) to alu_control, instantiated once.

Test Plan:
- add x3,x1,x2 (opcode 0110011, funct7b5 0), mem_ready = 1:
  - states FETCH, DECODE, EXECR, ALUWB
  - reg_write high only in cycle 4
  - alu_control = 000 in EXECR
- lw (0000011) with mem_ready low for 2 extra cycles in FETCH and 3 in MEMREAD:
  - ir_write pulses exactly once
  - MEMWB is reached at cycle 10
  - imm_src = 00 throughout
- sw (0100011):
  - mem_write held through the MEMWRITE wait cycles, reg_write never asserted
  - imm_src = 01
- beq (funct3 000):
  - zero = 1 -> pc_write = 1 in BRANCH
  - zero = 0 -> pc_write = 0
  - bne (001) gives the inverse
  - imm_src = 10, alu_control = 001
- jal (1101111):
  - pc_write in JAL, then reg_write in ALUWB
  - imm_src = 11
- opcode 0000000:
  - with MC_CTRL_TRAP_EN, illegal_instr = 1 and the FSM stays in TRAP for 20 cycles until rst_n pulse
  - without it, back to FETCH with illegal_instr = 0
  - rst_n low mid-MEMREAD -> all outputs 0 immediately
